// File: rtl/traffic_light_monitor_pkg.sv
// Shared encodings and defaults for the traffic light monitor.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        A_GRN   = 2'd1,
        B_GRN   = 2'd2,
        FAULT   = 2'd3
    } mon_state_e;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_PED          = 3'd2;
    localparam logic [2:0] FC_SHORT_GREEN  = 3'd3;
    localparam logic [2:0] FC_SHORT_ALLRED = 3'd4;
    localparam logic [2:0] FC_STARVE_A     = 3'd5;
    localparam logic [2:0] FC_STARVE_B     = 3'd6;

    localparam int DEF_MIN_GREEN  = 5;
    localparam int DEF_MIN_ALLRED = 1;
    localparam int DEF_MAX_WAIT   = 60;

    // Violation vector is indexed by fault code; the lowest set code wins.
    function automatic logic [2:0] first_fault(input logic [6:1] viol);
        logic [2:0] code;
        code = FC_NONE;
        for (int i = 6; i >= 1; i--) begin
            if (viol[i]) code = 3'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_sat_tick_counter.sv
// Saturating tick counter with synchronous clear and a terminal compare.
module sat_tick_counter #(
    parameter int TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          tick_i,
    input  logic [TW-1:0] term_i,
    output logic [TW-1:0] count_o,
    output logic          reached_o
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != {TW{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o   = count_q;
    assign reached_o = (count_q >= term_i);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety/timing observer for the traffic light controller.
// Optional starvation checks (codes 5/6) are enabled by TRAFFIC_MON_STARVATION_EN.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int TW         = 8,
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int MIN_ALLRED = DEF_MIN_ALLRED,
    parameter int MAX_WAIT   = DEF_MAX_WAIT,
    parameter int CW         = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          sa_i,
    input  logic          sb_i,
    input  logic          a_i,
    input  logic          b_i,
    input  logic          pa_i,
    input  logic          pb_i,
    input  logic          clr_i,
    output logic          fault_o,
    output logic [2:0]    fault_code_o,
    output logic [CW-1:0] phase_cnt_o,
    output logic [1:0]    state_o
);

    localparam logic DIRECT_ILLEGAL = (MIN_ALLRED > 0);

    mon_state_e    state_q, state_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic [CW-1:0] phase_q, phase_d;

    logic [6:1]    viol;
    logic [2:0]    newCode;
    logic          phaseInc;
    logic          faultClear;
    logic          dwellClear, dwellEn, dwellReached;
    logic [TW-1:0] dwellTerm, dwellCount;
    logic          starveA, starveB;
    logic          unusedBits;

    assign faultClear = clr_i && (state_q == FAULT);
    assign dwellClear = (state_d != state_q);
    assign dwellEn    = tick_i && (state_q != FAULT);
    // All-red dwell is judged against MIN_ALLRED, green dwell against MIN_GREEN.
    assign dwellTerm  = (state_q == ALL_RED) ? TW'(MIN_ALLRED) : TW'(MIN_GREEN);

    sat_tick_counter #(.TW(TW)) u_dwell (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (dwellClear),
        .tick_i   (dwellEn),
        .term_i   (dwellTerm),
        .count_o  (dwellCount),
        .reached_o(dwellReached)
    );

`ifdef TRAFFIC_MON_STARVATION_EN
    logic [TW-1:0] waitACount, waitBCount;
    logic          waitAEn, waitBEn, waitAReached, waitBReached;

    assign waitAEn = tick_i && sa_i && !a_i && (state_q != FAULT);
    assign waitBEn = tick_i && sb_i && !b_i && (state_q != FAULT);

    // Terminal is MAX_WAIT-1 so the fault fires on the tick that reaches MAX_WAIT.
    sat_tick_counter #(.TW(TW)) u_wait_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (a_i || !sa_i || faultClear),
        .tick_i   (waitAEn),
        .term_i   (TW'(MAX_WAIT - 1)),
        .count_o  (waitACount),
        .reached_o(waitAReached)
    );

    sat_tick_counter #(.TW(TW)) u_wait_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (b_i || !sb_i || faultClear),
        .tick_i   (waitBEn),
        .term_i   (TW'(MAX_WAIT - 1)),
        .count_o  (waitBCount),
        .reached_o(waitBReached)
    );

    assign starveA    = waitAEn && waitAReached;
    assign starveB    = waitBEn && waitBReached;
    assign unusedBits = ^{dwellCount, waitACount, waitBCount};
`else
    assign starveA    = 1'b0;
    assign starveB    = 1'b0;
    assign unusedBits = ^{dwellCount, sa_i, sb_i, 32'(MAX_WAIT)};
`endif

    always_comb begin
        viol                  = '0;
        state_d               = state_q;
        fault_d               = fault_q;
        code_d                = code_q;
        phase_d               = phase_q;
        phaseInc              = 1'b0;

        viol[FC_CONFLICT]     = a_i && b_i;
        viol[FC_PED]          = (pa_i && a_i) || (pb_i && b_i);
        viol[FC_STARVE_A]     = starveA;
        viol[FC_STARVE_B]     = starveB;

        case (state_q)
            ALL_RED: begin
                if (a_i && !b_i) begin
                    if (!dwellReached) viol[FC_SHORT_ALLRED] = 1'b1;
                    else               state_d = A_GRN;
                end else if (b_i && !a_i) begin
                    if (!dwellReached) viol[FC_SHORT_ALLRED] = 1'b1;
                    else               state_d = B_GRN;
                end
            end
            A_GRN: begin
                if (!a_i) begin
                    if (!dwellReached)               viol[FC_SHORT_GREEN]  = 1'b1;
                    else if (b_i && DIRECT_ILLEGAL)  viol[FC_SHORT_ALLRED] = 1'b1;
                    else begin
                        state_d  = b_i ? B_GRN : ALL_RED;
                        phaseInc = 1'b1;
                    end
                end
            end
            B_GRN: begin
                if (!b_i) begin
                    if (!dwellReached)               viol[FC_SHORT_GREEN]  = 1'b1;
                    else if (a_i && DIRECT_ILLEGAL)  viol[FC_SHORT_ALLRED] = 1'b1;
                    else begin
                        state_d  = a_i ? A_GRN : ALL_RED;
                        phaseInc = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        newCode = first_fault(viol);

        // FAULT absorbs everything: later violations and phase completions are ignored.
        if (state_q == FAULT) begin
            state_d = FAULT;
            if (faultClear) begin
                state_d = ALL_RED;
                fault_d = 1'b0;
                code_d  = FC_NONE;
            end
        end else if (newCode != FC_NONE) begin
            state_d = FAULT;
            fault_d = 1'b1;
            code_d  = newCode;
        end else if (phaseInc && (phase_q != {CW{1'b1}})) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ALL_RED;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            phase_q <= phase_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign phase_cnt_o  = phase_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor, run with TICK pulsed and TICK held high.
module tb_traffic_light_monitor;

    logic clk = 1'b0;
    logic rst, tick, sa, sb, a, b, pa, pb, clr;

    logic       fault;
    logic [2:0] code;
    logic [7:0] phase;
    logic [1:0] state;

    logic       dut2Fault;
    logic [2:0] dut2Code;
    logic [1:0] dut2Phase;
    logic [1:0] dut2State;

    int  checks = 0;
    int  errors = 0;
    bit  tickAlways = 1'b0;
    bit  starveEn = 1'b0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .sa_i(sa), .sb_i(sb),
        .a_i(a), .b_i(b), .pa_i(pa), .pb_i(pb), .clr_i(clr),
        .fault_o(fault), .fault_code_o(code), .phase_cnt_o(phase), .state_o(state)
    );

    // Narrow phase counter instance to observe saturation at 3.
    traffic_light_monitor #(.CW(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .sa_i(sa), .sb_i(sb),
        .a_i(a), .b_i(b), .pa_i(pa), .pb_i(pb), .clr_i(clr),
        .fault_o(dut2Fault), .fault_code_o(dut2Code), .phase_cnt_o(dut2Phase), .state_o(dut2State)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s%s: got %0d expected %0d", tickAlways ? "t1/" : "tp/", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic bV, input logic paV, input logic pbV,
                                 input logic saV, input logic sbV, input logic tickV, input int n);
        a = aV; b = bV; pa = paV; pb = pbV; sa = saV; sb = sbV; tick = tickV;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n ticks: either n back-to-back tick cycles, or tick/idle pairs.
    task automatic runTicks(input logic aV, input logic bV, input logic paV, input logic pbV,
                            input logic saV, input logic sbV, input int n);
        if (tickAlways) begin
            applyStimulus(aV, bV, paV, pbV, saV, sbV, 1'b1, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                applyStimulus(aV, bV, paV, pbV, saV, sbV, 1'b1, 1);
                applyStimulus(aV, bV, paV, pbV, saV, sbV, 1'b0, 1);
            end
        end
    endtask

    task automatic legalPhase(input bit streetB, input int greenTicks);
        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(!streetB, streetB, 0, 0, 0, 0, tickAlways, 1);
        runTicks(!streetB, streetB, 0, 0, 0, 0, greenTicks);
        applyStimulus(0, 0, 0, 0, 0, 0, tickAlways, 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic doClear();
        clr = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        clr = 1'b0;
    endtask

    task automatic runSuite();
        doReset();
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_fault", 32'(fault), 0);
        checkOutput("reset_code", 32'(code), 0);
        checkOutput("reset_phase", 32'(phase), 0);

        legalPhase(1'b0, 5);
        checkOutput("legal_a_phase", 32'(phase), 1);
        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("enter_b_state", 32'(state), 2);
        runTicks(0, 1, 0, 0, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("legal_cycle_phase", 32'(phase), 2);
        checkOutput("legal_cycle_fault", 32'(fault), 0);
        checkOutput("legal_cycle_state", 32'(state), 0);

        legalPhase(1'b0, 5);
        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, tickAlways, 1);
        runTicks(1, 0, 0, 0, 0, 0, 2);
        checkOutput("midrun_state", 32'(state), 1);
        checkOutput("midrun_phase", 32'(phase), 3);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        rst = 1'b0;
        checkOutput("rst_mid_state", 32'(state), 0);
        checkOutput("rst_mid_phase", 32'(phase), 0);
        checkOutput("rst_mid_fault", 32'(fault), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        legalPhase(1'b0, 5);
        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, tickAlways, 1);
        runTicks(1, 0, 0, 0, 0, 0, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("short_green_fault", 32'(fault), 1);
        checkOutput("short_green_code", 32'(code), 3);
        checkOutput("short_green_state", 32'(state), 3);
        checkOutput("short_green_phase", 32'(phase), 1);
        doClear();
        checkOutput("clr_fault", 32'(fault), 0);
        checkOutput("clr_code", 32'(code), 0);
        checkOutput("clr_state", 32'(state), 0);
        checkOutput("clr_keeps_phase", 32'(phase), 1);

        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 1);
        checkOutput("conflict_fault", 32'(fault), 1);
        checkOutput("conflict_code", 32'(code), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, tickAlways, 1);
        runTicks(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("sticky_code", 32'(code), 1);
        checkOutput("sticky_state", 32'(state), 3);
        checkOutput("frozen_phase", 32'(phase), 1);
        doClear();
        checkOutput("clr2_fault", 32'(fault), 0);
        checkOutput("clr2_state", 32'(state), 0);

        applyStimulus(1, 0, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("short_allred_code", 32'(code), 4);
        doClear();

        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, tickAlways, 1);
        runTicks(1, 0, 0, 0, 0, 0, 5);
        applyStimulus(0, 1, 0, 0, 0, 0, tickAlways, 1);
        checkOutput("direct_ab_code", 32'(code), 4);
        checkOutput("direct_ab_phase", 32'(phase), 1);
        doClear();

        runTicks(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, tickAlways, 1);
        applyStimulus(0, 1, 0, 1, 0, 0, tickAlways, 1);
        checkOutput("ped_code", 32'(code), 2);
        doClear();

        // 258 ticks would wrap an 8-bit counter to 2 (< MIN_GREEN); saturation keeps it legal.
        legalPhase(1'b0, 258);
        checkOutput("dwell_sat_fault", 32'(fault), 0);
        checkOutput("dwell_sat_phase", 32'(phase), 2);

        runTicks(0, 0, 0, 0, 0, 1, 59);
        checkOutput("wait59_fault", 32'(fault), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("sb_drop_fault", 32'(fault), 0);
        runTicks(0, 0, 0, 0, 0, 1, 59);
        runTicks(0, 0, 0, 0, 0, 1, 1);
        checkOutput("starve_b_fault", 32'(fault), starveEn ? 1 : 0);
        checkOutput("starve_b_code", 32'(code), starveEn ? 6 : 0);
        doClear();

        doReset();
        for (int i = 0; i < 5; i++) legalPhase(i[0], 5);
        checkOutput("five_phases", 32'(phase), 5);
        checkOutput("cw2_saturated", 32'(dut2Phase), 3);
        checkOutput("cw2_fault", 32'(dut2Fault), 0);
        checkOutput("cw2_code", 32'(dut2Code), 0);
        checkOutput("cw2_state", 32'(dut2State), 0);
    endtask

    initial begin
`ifdef TRAFFIC_MON_STARVATION_EN
        starveEn = 1'b1;
`endif
        rst = 1'b0; clr = 1'b0;
        tick = 1'b0; sa = 1'b0; sb = 1'b0; a = 1'b0; b = 1'b0; pa = 1'b0; pb = 1'b0;

        tickAlways = 1'b0;
        runSuite();
        tickAlways = 1'b1;
        runSuite();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
